ccg_vector_sequencer: RTL and testbench

- Drives a generated combinational circuit (N_IN inputs, N_OUT outputs) through every input vector, 0 to 2^N_IN-1, in order.
- Samples the circuit's response after a settle window.
- Streams each (vector, response) pair out over a valid/ready interface for dataset labelling.
- Compresses all responses into an MISR signature for fast equivalence checks.
- Sits between the generated netlist under characterisation and the dataset writer / scoreboard.

---
 rtl/ccg_seq_pkg.sv | 19 +
 rtl/ccg_vector_sequencer_misr.sv | 35 +++
 rtl/ccg_vector_sequencer.sv | 136 +++++++++++++
 tb/tb_ccg_vector_sequencer.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ccg_seq_pkg.sv
// Shared types and constants for the combinational-circuit vector sequencer.
// Holds FSM state codes, MISR defaults and the signature update function.
package ccg_seq_pkg;

  localparam int unsigned CCG_SIG_W = 16;
  localparam logic [CCG_SIG_W-1:0] CCG_MISR_POLY = 16'h1021;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_EMIT   = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  // One MISR step at the default width and polynomial
  function automatic logic [CCG_SIG_W-1:0] misr_next(input logic [CCG_SIG_W-1:0] sig,
                                                     input logic [CCG_SIG_W-1:0] data);
    misr_next = {sig[CCG_SIG_W-2:0], 1'b0} ^ (sig[CCG_SIG_W-1] ? CCG_MISR_POLY : '0) ^ data;
  endfunction

endpackage

// File: rtl/ccg_vector_sequencer_misr.sv
// Multiple-input signature register with synchronous clear and update enable.
module ccg_misr
  import ccg_seq_pkg::*;
#(
  parameter int unsigned     SIG_W     = CCG_SIG_W,
  parameter logic [SIG_W-1:0] MISR_POLY = CCG_MISR_POLY
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [SIG_W-1:0] data,
  output logic [SIG_W-1:0] sig
);

  logic [SIG_W-1:0] sig_q;
  logic [SIG_W-1:0] sig_d;

  always_comb begin
    sig_d = sig_q;
    if (clr) begin
      sig_d = '0;
    end else if (en) begin
      sig_d = {sig_q[SIG_W-2:0], 1'b0} ^ (sig_q[SIG_W-1] ? MISR_POLY : '0) ^ data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sig_q <= '0;
    else        sig_q <= sig_d;
  end

  assign sig = sig_q;

endmodule

// File: rtl/ccg_vector_sequencer.sv
// Sweeps every input vector through a combinational circuit, streams each
// (vector, response) pair over valid/ready and folds responses into a MISR.
module ccg_vector_sequencer
  import ccg_seq_pkg::*;
#(
  parameter int unsigned      N_IN      = 7,
  parameter int unsigned      N_OUT     = 7,
  parameter int unsigned      SIG_W     = CCG_SIG_W,
  parameter logic [SIG_W-1:0] MISR_POLY = CCG_MISR_POLY,
  parameter int unsigned      SETTLE    = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [N_IN-1:0]   vec_o,
  input  logic [N_OUT-1:0]  resp_i,
  output logic              pair_valid,
  input  logic              pair_ready,
  output logic [N_IN-1:0]   pair_vec,
  output logic [N_OUT-1:0]  pair_resp,
  output logic              busy,
  output logic              done,
  output logic [SIG_W-1:0]  signature
);

  localparam int unsigned      CNT_W     = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE - 1);
  localparam logic [N_IN:0]    VEC_LAST  = {1'b0, {N_IN{1'b1}}};

  logic [1:0]       state_q, state_d;
  logic [N_IN:0]    vec_q, vec_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pair_valid_q, pair_valid_d;
  logic [N_IN-1:0]  pair_vec_q, pair_vec_d;
  logic [N_OUT-1:0] pair_resp_q, pair_resp_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             misr_clr_c;
  logic             misr_en_c;

  always_comb begin
    state_d      = state_q;
    vec_d        = vec_q;
    cnt_d        = cnt_q;
    pair_valid_d = pair_valid_q;
    pair_vec_d   = pair_vec_q;
    pair_resp_d  = pair_resp_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    misr_clr_c   = 1'b0;
    misr_en_c    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_SETTLE;
          vec_d      = '0;
          cnt_d      = SETTLE_LD;
          busy_d     = 1'b1;
          misr_clr_c = 1'b1;
        end
      end
      ST_SETTLE: begin
        // Response is only trusted on the final settle cycle
        if (cnt_q == '0) begin
          pair_resp_d  = resp_i;
          pair_vec_d   = vec_q[N_IN-1:0];
          pair_valid_d = 1'b1;
          state_d      = ST_EMIT;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_EMIT: begin
        if (pair_valid_q && pair_ready) begin
          misr_en_c    = 1'b1;
          pair_valid_d = 1'b0;
          if (vec_q == VEC_LAST) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            vec_d   = vec_q + 1'b1;
            cnt_d   = SETTLE_LD;
            state_d = ST_SETTLE;
          end
        end
      end
      ST_DONE: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      vec_q        <= '0;
      cnt_q        <= '0;
      pair_valid_q <= 1'b0;
      pair_vec_q   <= '0;
      pair_resp_q  <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      vec_q        <= vec_d;
      cnt_q        <= cnt_d;
      pair_valid_q <= pair_valid_d;
      pair_vec_q   <= pair_vec_d;
      pair_resp_q  <= pair_resp_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  ccg_misr #(
    .SIG_W     (SIG_W),
    .MISR_POLY (MISR_POLY)
  ) u_misr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (misr_clr_c),
    .en    (misr_en_c),
    .data  (SIG_W'(pair_resp_q)),
    .sig   (signature)
  );

  assign vec_o      = vec_q[N_IN-1:0];
  assign pair_valid = pair_valid_q;
  assign pair_vec   = pair_vec_q;
  assign pair_resp  = pair_resp_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_ccg_vector_sequencer.sv
// Randomized and directed bench for ccg_vector_sequencer against a pair/signature
// reference model; a second instance runs with a 3-cycle settle window.
module tb_ccg_vector_sequencer;

  localparam int NV = 128;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       start, pair_valid, pair_ready, busy, done;
  logic [6:0] vec_o, resp_i, pair_vec, pair_resp;
  logic [15:0] signature;

  logic       start3, pv3, busy3, done3;
  logic       rdy3 = 1'b1;
  logic [6:0] vec3, resp3, pvec3, presp3;
  logic [15:0] sig3;

  ccg_vector_sequencer #(.N_IN(7), .N_OUT(7), .SIG_W(16), .MISR_POLY(16'h1021), .SETTLE(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .vec_o(vec_o), .resp_i(resp_i),
    .pair_valid(pair_valid), .pair_ready(pair_ready), .pair_vec(pair_vec),
    .pair_resp(pair_resp), .busy(busy), .done(done), .signature(signature)
  );

  ccg_vector_sequencer #(.N_IN(7), .N_OUT(7), .SIG_W(16), .MISR_POLY(16'h1021), .SETTLE(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .vec_o(vec3), .resp_i(resp3),
    .pair_valid(pv3), .pair_ready(rdy3), .pair_vec(pvec3),
    .pair_resp(presp3), .busy(busy3), .done(done3), .signature(sig3)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model state
  int         resp_mode = 0;
  logic [6:0] tbl [NV];
  logic [6:0] glitch = '0;
  int         exp_k = 0;
  int         msig = 0;
  bit         chk_en = 1'b0;
  int         k3 = 0;

  function automatic int mstep(input int s, input int d);
    int t;
    t = s * 2;
    if (t >= 65536) t = (t - 65536) ^ 'h1021;
    return t ^ d;
  endfunction

  function automatic int fexp(input int k);
    case (resp_mode)
      0:       return k;
      1:       return 0;
      default: return int'(tbl[k]);
    endcase
  endfunction

  // Circuit under characterisation: pure function of vec_o, garbage while a pair is held
  always_comb begin
    if (pair_valid) resp_i = glitch;
    else begin
      case (resp_mode)
        0:       resp_i = vec_o;
        1:       resp_i = '0;
        default: resp_i = tbl[vec_o];
      endcase
    end
  end

  always @(negedge clk) glitch <= 7'($urandom);

  // Slow circuit: output is the identity only once the input has been stable long enough
  logic [6:0] d1 = '0, d2 = '0;
  always @(posedge clk) begin
    d1 <= vec3;
    d2 <= d1;
  end
  assign resp3 = (d1 == vec3 && d2 == vec3) ? vec3 : ~vec3;

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      if (busy) check("sig_track", int'(signature), msig);
      if (pair_valid) begin
        check("pair_vec", int'(pair_vec), exp_k);
        check("pair_resp", int'(pair_resp), fexp(exp_k));
        check("vec_o", int'(vec_o), exp_k);
        if (pair_ready) begin
          msig = mstep(msig, fexp(exp_k));
          exp_k++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && pv3) begin
      check("s3_vec", int'(pvec3), k3);
      check("s3_resp", int'(presp3), k3);
      if (rdy3) k3++;
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_vec_o"}, int'(vec_o), 0);
    check({tag, "_pair_vec"}, int'(pair_vec), 0);
    check({tag, "_pair_resp"}, int'(pair_resp), 0);
    check({tag, "_sig"}, int'(signature), 0);
    check({tag, "_valid"}, int'(pair_valid), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
  endtask

  // rmode: 0 ready high, 1 random ready, 2 ten-cycle stall on vector 5
  task automatic sweep(input int rmode, input int rsp, input bit abuse,
                       output int done_edge, output int final_sig);
    int n;
    int stall;
    int fold;
    bit abused;
    stall = 0;
    abused = 1'b0;
    resp_mode = rsp;
    exp_k = 0;
    msig = 0;
    chk_en = 1'b1;
    @(posedge clk); #1;
    start = 1'b1;
    pair_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (n = 1; n <= 4000; n++) begin
      @(negedge clk);
      if (n == 1) begin
        check("start_busy", int'(busy), 1);
        check("start_vec", int'(vec_o), 0);
      end
      if (done) break;
      @(posedge clk); #1;
      start = 1'b0;
      case (rmode)
        1: pair_ready = ($urandom_range(0, 3) != 0);
        2: begin
          if (vec_o == 7'd5 && pair_valid && stall < 10) begin
            pair_ready = 1'b0;
            stall++;
          end else pair_ready = 1'b1;
        end
        default: pair_ready = 1'b1;
      endcase
      if (abuse && !abused && vec_o == 7'd20) begin
        start = 1'b1;
        abused = 1'b1;
      end
    end
    if (n > 4000) check("done_timeout", 0, 1);
    done_edge = n - 1;
    final_sig = int'(signature);
    fold = 0;
    for (int k = 0; k < NV; k++) fold = mstep(fold, fexp(k));
    check("pair_count", exp_k, NV);
    check("sig_fold", final_sig, fold);
    check("sig_model", final_sig, msig);
    if (abuse) start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    pair_ready = 1'b1;
    @(negedge clk);
    check("done_pulse", int'(done), 0);
    check("busy_after", int'(busy), 0);
    repeat (3) @(negedge clk);
    check("idle_busy", int'(busy), 0);
    check("idle_valid", int'(pair_valid), 0);
    check("idle_vec", int'(vec_o), 127);
    check("idle_sig", int'(signature), final_sig);
  endtask

  initial begin
    int de;
    int lb_sig;
    int sig_tmp;
    int n;
    start = 1'b0;
    start3 = 1'b0;
    pair_ready = 1'b0;
    for (int k = 0; k < NV; k++) tbl[k] = 7'($urandom);

    check("pin_shift", mstep(0, 1), 'h0001);
    check("pin_poly", mstep('h8000, 0), 'h1021);
    check("pin_mix", mstep('h8001, 'h7f), 'h105c);

    #23;
    check_all_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    sweep(0, 0, 1'b0, de, lb_sig);
    check("loop_done_edge", de, 256);

    sweep(0, 1, 1'b0, de, sig_tmp);
    check("zero_sig", sig_tmp, 'h0000);
    check("zero_done_edge", de, 256);

    sweep(2, 0, 1'b0, de, sig_tmp);
    check("stall_sig", sig_tmp, lb_sig);
    check("stall_done_edge", de, 266);

    sweep(0, 0, 1'b1, de, sig_tmp);
    check("abuse_sig", sig_tmp, lb_sig);
    check("abuse_done_edge", de, 256);

    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < NV; k++) tbl[k] = 7'($urandom);
      sweep(1, 2, 1'b0, de, sig_tmp);
    end

    // Slow circuit with SETTLE=3
    k3 = 0;
    @(posedge clk); #1;
    start3 = 1'b1;
    @(posedge clk); #1;
    start3 = 1'b0;
    for (n = 1; n <= 3000; n++) begin
      @(negedge clk);
      if (done3) break;
    end
    if (n > 3000) check("s3_timeout", 0, 1);
    check("s3_done_edge", n - 1, 512);
    check("s3_pairs", k3, NV);
    check("s3_sig", int'(sig3), lb_sig);
    @(negedge clk);
    check("s3_busy_after", int'(busy3), 0);

    // Reset in the middle of a sweep
    resp_mode = 0;
    exp_k = 0;
    msig = 0;
    chk_en = 1'b1;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (n = 0; n < 1000 && vec_o != 7'd40; n++) @(posedge clk);
    if (n >= 1000) check("rst_reach_timeout", 0, 1);
    #3;
    chk_en = 1'b0;
    rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    repeat (5) begin
      @(negedge clk);
      check("midrst_no_done", int'(done), 0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    sweep(0, 0, 1'b0, de, sig_tmp);
    check("rst_sweep_sig", sig_tmp, lb_sig);
    check("rst_sweep_edge", de, 256);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
